host_pktend_ctrl: RTL and testbench

HOST_PKTEND_CTRL -- requirements
Module: host_pktend_ctrl

---
 rtl/da_platform_pkg.sv | 16 +
 rtl/host_pktend_ctrl_if.sv | 34 +++
 rtl/skid_buffer.sv | 70 +++++++
 rtl/host_pktend_ctrl.sv | 117 +++++++++++
 tb/tb_host_pktend_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/da_platform_pkg.sv
// Shared platform package: default stream-controller constants and the
// PKTEND controller state enumeration.
package da_platform;

    // One full FX2 bulk packet: 512 bytes of 16-bit words.
    localparam int unsigned pkt_words_default    = 256;
    // Idle cycles before a partial packet is committed.
    localparam int unsigned idle_timeout_default = 4096;

    typedef enum logic [1:0] {
        StEmpty,
        StPartial,
        StArm
    } pktend_state_e;

endpackage

// File: rtl/host_pktend_ctrl_if.sv
// Stream bundle between the host_out source, the PKTEND controller and the
// FX2 adapter.
//   master : environment side (drives upstream word, downstream ready, flush)
//   slave  : controller side (drives in_ready, downstream word, pktend_arm,
//            word_count)
interface host_pktend_ctrl_if
    import da_platform::*;
#(
    parameter int unsigned host_width = 16,
    parameter int unsigned pkt_words  = pkt_words_default
);
    localparam int unsigned count_width = $clog2(pkt_words);

    logic [host_width-1:0]  in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [host_width-1:0]  out_data;
    logic                   out_valid;
    logic                   out_ready;
    logic                   flush_req;
    logic                   pktend_arm;
    logic [count_width-1:0] word_count;

    modport master (
        output in_data, in_valid, out_ready, flush_req,
        input  in_ready, out_data, out_valid, pktend_arm, word_count
    );

    modport slave (
        input  in_data, in_valid, out_ready, flush_req,
        output in_ready, out_data, out_valid, pktend_arm, word_count
    );

endinterface

// File: rtl/skid_buffer.sv
// Two-entry skid buffer with fully registered outputs.
//   in_data/in_valid/in_ready    : upstream valid/ready stream
//   out_data/out_valid/out_ready : downstream valid/ready stream
// in_ready depends only on state, so there is no combinational path from
// out_ready back to in_ready. A word accepted into an empty buffer is on the
// output the next cycle.
module skid_buffer #(
    parameter int unsigned width = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [width-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);
    logic [width-1:0] out_data_q, out_data_d;
    logic [width-1:0] skid_data_q, skid_data_d;
    logic             out_valid_q, out_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             push;

    // The skid entry only fills behind a valid output entry, so it alone
    // marks the buffer as full.
    assign in_ready = ~skid_valid_q;
    assign push     = in_valid & ~skid_valid_q;

    always_comb begin
        out_data_d   = out_data_q;
        out_valid_d  = out_valid_q;
        skid_data_d  = skid_data_q;
        skid_valid_d = skid_valid_q;
        if (out_valid_q && !out_ready) begin
            // Output stalled: hold it, park any new word in the skid entry.
            if (push) begin
                skid_data_d  = in_data;
                skid_valid_d = 1'b1;
            end
        end else if (skid_valid_q) begin
            out_data_d   = skid_data_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else begin
            out_valid_d = push;
            if (push) begin
                out_data_d = in_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            skid_data_q  <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_valid_q  <= out_valid_d;
            skid_data_q  <= skid_data_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: rtl/host_pktend_ctrl.sv
// PKTEND controller: passes host_out words to the FX2 adapter through a skid
// buffer, counts words per USB packet and requests a short-packet commit
// (pktend_arm) after an idle timeout or on flush_req.
//   clk, aresetn : sole clock, asynchronous active-low reset
//   bus (slave)  : in_* upstream stream, out_* downstream stream, flush_req,
//                  pktend_arm pulse, word_count of the current packet
module host_pktend_ctrl
    import da_platform::*;
#(
    parameter int unsigned host_width   = 16,
    parameter int unsigned pkt_words    = pkt_words_default,
    parameter int unsigned idle_timeout = idle_timeout_default
) (
    input logic               clk,
    input logic               aresetn,
    host_pktend_ctrl_if.slave bus
);
    localparam int unsigned count_width = $clog2(pkt_words);
    localparam int unsigned idle_width  = $clog2(idle_timeout + 1);

    logic                   rst_sync_q;
    logic                   rst_n;
    pktend_state_e          state_q, state_d;
    logic [count_width-1:0] word_count_q, word_count_d;
    logic [idle_width-1:0]  idle_q, idle_d;
    logic                   skid_in_ready, skid_out_valid, skid_out_ready;
    logic                   arm, xfer, wrap, timeout;

    // Assertion is immediate; release takes effect on the first clk edge, so
    // in_ready rises on that edge.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rst_sync_q <= 1'b0;
        end else begin
            rst_sync_q <= 1'b1;
        end
    end
    assign rst_n = rst_sync_q;

    assign arm = (state_q == StArm);

    skid_buffer #(
        .width(host_width)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (bus.in_data),
        .in_valid (bus.in_valid & rst_n),
        .in_ready (skid_in_ready),
        .out_data (bus.out_data),
        .out_valid(skid_out_valid),
        .out_ready(skid_out_ready)
    );

    // The arm cycle freezes the downstream side so the commit sees a quiet bus.
    assign bus.in_ready    = skid_in_ready & rst_n;
    assign bus.out_valid   = skid_out_valid & ~arm;
    assign skid_out_ready  = bus.out_ready & ~arm;
    assign xfer            = bus.out_valid & bus.out_ready;
    // pkt_words is a power of two: the last word index is all ones.
    assign wrap            = xfer & (&word_count_q);

    always_comb begin
        idle_d = idle_q;
        if (xfer || arm || word_count_q == '0) begin
            idle_d = '0;
        end else if (idle_q != idle_width'(idle_timeout)) begin
            idle_d = idle_q + 1'b1;
        end
    end

    // Timeout fires on the edge where the counter reaches idle_timeout.
    assign timeout = (idle_d == idle_width'(idle_timeout));

    always_comb begin
        state_d      = state_q;
        word_count_d = xfer ? word_count_q + 1'b1 : word_count_q;
        unique case (state_q)
            StEmpty: begin
                if (xfer) begin
                    state_d = StPartial;
                end
            end
            StPartial: begin
                if (wrap) begin
                    state_d = StEmpty;
                end else if (!xfer && (timeout || bus.flush_req)) begin
                    state_d = StArm;
                end
            end
            StArm: begin
                state_d      = StEmpty;
                word_count_d = '0;
            end
            default: begin
                state_d      = StEmpty;
                word_count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StEmpty;
            word_count_q <= '0;
            idle_q       <= '0;
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            idle_q       <= idle_d;
        end
    end

    assign bus.pktend_arm = arm;
    assign bus.word_count = word_count_q;

endmodule

// File: tb/tb_host_pktend_ctrl.sv
// Self-checking bench for host_pktend_ctrl: a directed vector table, directed
// multi-cycle sequences and randomized traffic, all checked every cycle
// against a queue-based reference model of the stream and packet rules.
module tb_host_pktend_ctrl;
    localparam int unsigned host_width   = 16;
    localparam int unsigned pkt_words    = 256;
    localparam int unsigned idle_timeout = 16;
    localparam int          tmo          = 16;
    localparam int          pw           = 256;

    logic clk     = 1'b0;
    logic aresetn = 1'b0;
    always #5 clk = ~clk;

    host_pktend_ctrl_if #(.host_width(host_width), .pkt_words(pkt_words)) bus ();

    host_pktend_ctrl #(
        .host_width  (host_width),
        .pkt_words   (pkt_words),
        .idle_timeout(idle_timeout)
    ) dut (
        .clk    (clk),
        .aresetn(aresetn),
        .bus    (bus)
    );

    // Reference model: words in flight, packet word count, idle cycles since
    // the last transfer, pending commit pulse, reset release seen.
    logic [host_width-1:0] exp_q[$];
    int m_wc, m_idle;
    bit m_arm, m_sync;

    int n_vec = 0, n_err = 0, cyc = 0;
    int arm_seen = 0, xfer_seen = 0, last_xfer_cyc = 0, last_arm_cyc = 0;
    bit last_acc;

    typedef struct packed {
        logic        iv;
        logic [15:0] id;
        logic        ordy;
        logic        fl;
        logic        e_irdy;
        logic        e_ov;
        logic [15:0] e_od;
        logic        e_arm;
        logic [7:0]  e_wc;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_wc   = 0;
        m_idle = 0;
        m_arm  = 1'b0;
        m_sync = 1'b0;
    endtask

    task automatic drive(input bit iv, input logic [15:0] d, input bit ordy, input bit fl);
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.flush_req = fl;
    endtask

    // Called at the negedge: compare against the model, advance the model
    // across the coming posedge, then move to just after that edge.
    task automatic tick();
        bit rdy, ov, xfer, acc;
        int wc_n, idle_n;
        rdy = m_sync && exp_q.size() < 2;
        ov  = exp_q.size() > 0 && !m_arm;
        check("in_ready", 32'(bus.in_ready), 32'(rdy));
        check("out_valid", 32'(bus.out_valid), 32'(ov));
        if (ov) check("out_data", 32'(bus.out_data), 32'(exp_q[0]));
        check("pktend_arm", 32'(bus.pktend_arm), 32'(m_arm));
        check("word_count", 32'(bus.word_count), 32'(m_wc));
        if (bus.pktend_arm === 1'b1) begin
            arm_seen++;
            last_arm_cyc = cyc;
        end
        xfer = ov && bus.out_ready;
        acc  = rdy && bus.in_valid;
        if (xfer) begin
            xfer_seen++;
            last_xfer_cyc = cyc;
        end
        last_acc = acc;
        if (!aresetn) begin
            model_reset();
        end else if (!m_sync) begin
            m_sync = 1'b1;
        end else begin
            if (m_arm) begin
                m_wc   = 0;
                m_idle = 0;
                m_arm  = 1'b0;
            end else begin
                idle_n = (xfer || m_wc == 0) ? 0 : ((m_idle + 1 > tmo) ? tmo : m_idle + 1);
                wc_n   = xfer ? (m_wc + 1) % pw : m_wc;
                m_arm  = m_wc != 0 && !xfer && (idle_n == tmo || bus.flush_req);
                m_wc   = wc_n;
                m_idle = idle_n;
            end
            if (xfer) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(bus.in_data);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int sent, got0, budget, c, w2c;

        // 3 words, flush two cycles after the last transfer, then a flush in EMPTY.
        tbl[0] = '{1'b1, 16'h00a1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};
        tbl[1] = '{1'b1, 16'h00a2, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00a1, 1'b0, 8'd0};
        tbl[2] = '{1'b1, 16'h00a3, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00a2, 1'b0, 8'd1};
        tbl[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00a3, 1'b0, 8'd2};
        tbl[4] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd3};
        tbl[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd3};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 8'd3};
        tbl[7] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};
        tbl[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};
        tbl[9] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 8'd0};

        drive(1'b0, 16'h0, 1'b0, 1'b0);
        model_reset();
        step();
        step();
        aresetn = 1'b1;
        step();
        step();

        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].ordy, tbl[i].fl);
            @(negedge clk);
            check("tbl_in_ready", 32'(bus.in_ready), 32'(tbl[i].e_irdy));
            check("tbl_out_valid", 32'(bus.out_valid), 32'(tbl[i].e_ov));
            if (tbl[i].e_ov) check("tbl_out_data", 32'(bus.out_data), 32'(tbl[i].e_od));
            check("tbl_arm", 32'(bus.pktend_arm), 32'(tbl[i].e_arm));
            check("tbl_wc", 32'(bus.word_count), 32'(tbl[i].e_wc));
            tick();
        end

        // Full packet at full rate: natural wrap, no commit pulse.
        arm_seen = 0;
        xfer_seen = 0;
        sent = 0;
        budget = 0;
        while (sent < 256 && budget < 400) begin
            drive(1'b1, 16'(32'h1000 + sent), 1'b1, 1'b0);
            step();
            if (last_acc) sent++;
            budget++;
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        repeat (4) step();
        check("stream_xfers", 32'(xfer_seen), 32'd256);
        check("stream_arms", 32'(arm_seen), 32'd0);
        @(negedge clk);
        check("stream_wc", 32'(bus.word_count), 32'd0);
        tick();

        // 5 words then idle: one pulse after idle_timeout idle cycles.
        arm_seen = 0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'(32'h2000 + i), 1'b1, 1'b0);
            step();
        end
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        repeat (30) step();
        check("idle_arms", 32'(arm_seen), 32'd1);
        check("idle_arm_delay", 32'(last_arm_cyc - last_xfer_cyc), 32'(tmo + 1));
        @(negedge clk);
        check("idle_wc", 32'(bus.word_count), 32'd0);
        tick();

        // Transfer landing on the timeout cycle wins and restarts the count.
        arm_seen = 0;
        xfer_seen = 0;
        drive(1'b1, 16'h3001, 1'b1, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        step();
        check("tmo_w1_xfer", 32'(xfer_seen), 32'd1);
        c = last_xfer_cyc;
        while (cyc < c + tmo - 1) step();
        drive(1'b1, 16'h3002, 1'b1, 1'b0);
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        step();
        w2c = last_xfer_cyc;
        check("tmo_w2_cycle", 32'(w2c - c), 32'(tmo));
        check("tmo_no_arm", 32'(arm_seen), 32'd0);
        @(negedge clk);
        check("tmo_wc", 32'(bus.word_count), 32'd2);
        tick();
        repeat (25) step();
        check("tmo_restart_arms", 32'(arm_seen), 32'd1);
        check("tmo_restart_delay", 32'(last_arm_cyc - w2c), 32'(tmo + 1));

        // Random traffic, downstream stalls half the time, sporadic flushes.
        sent = 0;
        budget = 0;
        got0 = xfer_seen;
        while (sent < 1000 && budget < 20000) begin
            drive(($urandom_range(0, 99) < 70), 16'($urandom), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 99) < 3));
            step();
            if (last_acc) sent++;
            budget++;
        end
        check("rand_sent", 32'(sent), 32'd1000);
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        repeat (10) step();
        check("rand_received", 32'(xfer_seen - got0), 32'd1000);
        check("rand_model_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-packet at word_count=100.
        budget = 0;
        while (m_wc != 100 && budget < 600) begin
            drive(1'b1, 16'(32'h4000 + budget), 1'b1, 1'b0);
            step();
            budget++;
        end
        check("rst_reach_wc", 32'(m_wc), 32'd100);
        #2;
        aresetn = 1'b0;
        #1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_arm", 32'(bus.pktend_arm), 32'd0);
        check("rst_wc", 32'(bus.word_count), 32'd0);
        model_reset();
        step();
        step();
        drive(1'b0, 16'h0, 1'b1, 1'b0);
        aresetn = 1'b1;
        arm_seen = 0;
        xfer_seen = 0;
        repeat (30) step();
        check("rst_no_stale", 32'(xfer_seen), 32'd0);
        check("rst_no_arm", 32'(arm_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
